// File: rtl/dma_pkg.sv
// Shared encodings for the DMA controller: bus widths, trigger timings,
// address-control modes, config register selects, CNT field positions.
package dma_pkg;
  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_WORD = 2'b10;

  localparam logic [1:0] T_IMM = 2'd0;
  localparam logic [1:0] T_VBL = 2'd1;
  localparam logic [1:0] T_HBL = 2'd2;
  localparam logic [1:0] T_SPC = 2'd3;

  localparam logic [1:0] AC_INC = 2'd0;
  localparam logic [1:0] AC_DEC = 2'd1;
  localparam logic [1:0] AC_FIX = 2'd2;
  localparam logic [1:0] AC_RLD = 2'd3;

  localparam logic [1:0] REG_SAD = 2'd0;
  localparam logic [1:0] REG_DAD = 2'd1;
  localparam logic [1:0] REG_CNT = 2'd2;

  localparam int CNT_DCTL = 20;
  localparam int CNT_SCTL = 22;
  localparam int CNT_RPT  = 25;
  localparam int CNT_W32  = 26;
  localparam int CNT_TIM  = 28;
  localparam int CNT_IRQ  = 30;
  localparam int CNT_EN   = 31;

  typedef enum logic [1:0] {OWN_CPU, OWN_RD, OWN_WR} owner_e;

  function automatic logic [31:0] step_addr(input logic [31:0] a, input logic [1:0] ctl,
                                            input logic is_dst, input logic w32);
    logic [31:0] st;
    st = w32 ? 32'd4 : 32'd2;
    case (ctl)
      AC_INC:  return a + st;
      AC_DEC:  return a - st;
      AC_RLD:  return is_dst ? a + st : a;
      default: return a;
    endcase
  endfunction

  function automatic logic [31:0] align(input logic [31:0] a, input logic w32);
    return w32 ? {a[31:2], 2'b00} : {a[31:1], 1'b0};
  endfunction

  function automatic logic [1:0] first_set(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (v[i]) idx = 2'(i);
    return idx;
  endfunction
endpackage

// File: rtl/dma_channel.sv
// One DMA channel: shadow config, working src/dst/count, pending flag,
// address stepping and completion/reload handling.
module dma_channel
  import dma_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cfg_we_i,
  input  logic [1:0]  cfg_reg_i,
  input  logic [31:0] cfg_data_i,
  input  logic        trig_vblank_i,
  input  logic        trig_hblank_i,
  input  logic        unit_done_i,
  output logic [31:0] src_o,
  output logic [31:0] dst_o,
  output logic        w32_o,
  output logic        pending_o,
  output logic        last_o,
  output logic        en_o,
  output logic        irq_o
);
  logic [31:0]        sad_q, dad_q, src_q, dst_q;
  logic [COUNT_W-1:0] count_q, rem_q;
  logic [1:0]         dctl_q, sctl_q, tim_q;
  logic               rpt_q, w32_q, irqen_q, en_q, pend_q, irq_q;
  logic               unused_cfg;

  assign unused_cfg = ^{cfg_data_i[19:16], cfg_data_i[24], cfg_data_i[27]};

  assign src_o     = align(src_q, w32_q);
  assign dst_o     = align(dst_q, w32_q);
  assign w32_o     = w32_q;
  assign pending_o = pend_q;
  assign last_o    = (rem_q == COUNT_W'(1));
  assign en_o      = en_q;
  assign irq_o     = irq_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sad_q <= '0; dad_q <= '0; src_q <= '0; dst_q <= '0;
      count_q <= '0; rem_q <= '0; dctl_q <= '0; sctl_q <= '0; tim_q <= '0;
      rpt_q <= 1'b0; w32_q <= 1'b0; irqen_q <= 1'b0;
      en_q <= 1'b0; pend_q <= 1'b0; irq_q <= 1'b0;
    end else begin
      irq_q <= 1'b0;
      if (en_q && ((trig_vblank_i && tim_q == T_VBL) || (trig_hblank_i && tim_q == T_HBL)))
        pend_q <= 1'b1;
      if (unit_done_i) begin
        src_q <= step_addr(src_q, sctl_q, 1'b0, w32_q);
        dst_q <= step_addr(dst_q, dctl_q, 1'b1, w32_q);
        rem_q <= rem_q - COUNT_W'(1);
        // An aborted channel may still finish its in-flight unit; it never completes.
        if (last_o && en_q) begin
          irq_q  <= irqen_q;
          pend_q <= 1'b0;
          if (rpt_q && tim_q != T_IMM) begin
            rem_q <= count_q;
            if (dctl_q == AC_RLD) dst_q <= dad_q;
          end else begin
            en_q <= 1'b0;
          end
        end
      end
      if (cfg_we_i) begin
        case (cfg_reg_i)
          REG_SAD: sad_q <= cfg_data_i;
          REG_DAD: dad_q <= cfg_data_i;
          REG_CNT: begin
            count_q <= cfg_data_i[COUNT_W-1:0];
            dctl_q  <= cfg_data_i[CNT_DCTL +: 2];
            sctl_q  <= cfg_data_i[CNT_SCTL +: 2];
            tim_q   <= cfg_data_i[CNT_TIM +: 2];
            rpt_q   <= cfg_data_i[CNT_RPT];
            w32_q   <= cfg_data_i[CNT_W32];
            irqen_q <= cfg_data_i[CNT_IRQ];
            if (cfg_data_i[CNT_EN] && !en_q) begin
              en_q   <= 1'b1;
              src_q  <= sad_q;
              dst_q  <= dad_q;
              rem_q  <= cfg_data_i[COUNT_W-1:0];
              pend_q <= (cfg_data_i[CNT_TIM +: 2] == T_IMM);
            end else if (!cfg_data_i[CNT_EN]) begin
              en_q   <= 1'b0;
              pend_q <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: rtl/dma_ctrl.sv
// Four-channel fixed-priority DMA controller: bus owner FSM, priority
// selection and CPU/DMA memory bus multiplexing.
module dma_ctrl
  import dma_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [1:0]  cpu_width,
  input  logic        cpu_read,
  input  logic        cpu_write,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ok,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_width,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ok,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_ch,
  input  logic [1:0]  cfg_reg,
  input  logic [31:0] cfg_data,
  input  logic        trig_vblank,
  input  logic        trig_hblank,
  output logic [3:0]  ch_en,
  output logic [3:0]  irq
);
  owner_e      state_q;
  logic [1:0]  ach_q;
  logic [31:0] data_q;
  logic [3:0]  pend, last, done, w32, pend_d;
  logic [31:0] src [4];
  logic [31:0] dst [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_ch
    assign done[gi] = (state_q == OWN_WR) && mem_ok && (ach_q == 2'(gi));
    dma_channel #(.COUNT_W(COUNT_W)) u_ch (
      .clk          (clk),
      .rstn         (rstn),
      .cfg_we_i     (cfg_we && (cfg_ch == 2'(gi))),
      .cfg_reg_i    (cfg_reg),
      .cfg_data_i   (cfg_data),
      .trig_vblank_i(trig_vblank),
      .trig_hblank_i(trig_hblank),
      .unit_done_i  (done[gi]),
      .src_o        (src[gi]),
      .dst_o        (dst[gi]),
      .w32_o        (w32[gi]),
      .pending_o    (pend[gi]),
      .last_o       (last[gi]),
      .en_o         (ch_en[gi]),
      .irq_o        (irq[gi])
    );
  end

  // Pending set as it will stand once the finishing unit's completion lands.
  assign pend_d = pend & ~(done & last);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= OWN_CPU;
      ach_q   <= 2'd0;
      data_q  <= '0;
    end else begin
      case (state_q)
        OWN_CPU:
          if (|pend && (!(cpu_read || cpu_write) || mem_ok)) begin
            state_q <= OWN_RD;
            ach_q   <= first_set(pend);
          end
        OWN_RD:
          if (mem_ok) begin
            data_q  <= mem_rdata;
            state_q <= OWN_WR;
          end
        OWN_WR:
          if (mem_ok) begin
            if (|pend_d) begin
              state_q <= OWN_RD;
              ach_q   <= first_set(pend_d);
            end else begin
              state_q <= OWN_CPU;
            end
          end
        default: state_q <= OWN_CPU;
      endcase
    end
  end

  assign cpu_rdata = mem_rdata;

  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_width = cpu_width;
    mem_read  = cpu_read;
    mem_write = cpu_write;
    cpu_ok    = mem_ok;
    if (state_q != OWN_CPU) begin
      mem_wdata = data_q;
      mem_width = w32[ach_q] ? W_WORD : W_HALF;
      mem_read  = (state_q == OWN_RD);
      mem_write = (state_q == OWN_WR);
      mem_addr  = (state_q == OWN_RD) ? src[ach_q] : dst[ach_q];
      cpu_ok    = 1'b0;
    end
  end
endmodule

// File: doc/dma_ctrl.md
# dma_ctrl

Four-channel, fixed-priority DMA controller that owns the path between `cpu_armv4t` and `memory`. When idle it forwards CPU memory transactions unchanged. When a channel becomes pending, it takes the bus at a CPU transaction boundary, stalls the CPU, and performs read/write unit copies. Channels are configured through a register write port driven by `io_register`; triggers come from the graphics timing.

## Interface
Parameters:
- COUNT_W, 16, word-count field width; count 0 means 2^COUNT_W units

Ports:
- clk  in  1  system clock (25 MHz domain); one clock; reset is synchronous and active-low
- rstn  in  1  synchronous active-low reset
- cpu_addr / cpu_wdata  in  32 / 32  CPU request address / write data
- cpu_width  in  2  01 halfword, 10 word, 00 byte
- cpu_read / cpu_write  in  1 / 1  CPU request strobes, held until cpu_ok
- cpu_rdata  out  32  read data (always = mem_rdata)
- cpu_ok  out  1  CPU transaction complete
- mem_addr / mem_wdata  out  32 / 32  memory request address / write data
- mem_width  out  2  memory width, same encoding
- mem_read / mem_write  out  1 / 1  memory strobes
- mem_rdata  in  32  memory read data
- mem_ok  in  1  memory transaction complete
- cfg_we  in  1  config write strobe
- cfg_ch  in  2  channel select
- cfg_reg  in  2  0 SAD, 1 DAD, 2 CNT
- cfg_data  in  32  CNT layout: [15:0] count, [21:20] dest ctl, [23:22] src ctl, [25] repeat, [26] 32-bit, [29:28] timing, [30] irq_en, [31] enable
- trig_vblank / trig_hblank  in  1 / 1  single-cycle trigger pulses
- ch_en  out  4  live enable bit per channel
- irq  out  4  one-cycle completion pulse per channel

## Operation
- Per channel: shadow SAD/DAD/CNT registers plus working src, dst and remaining count, and a pending flag.
- Enable edge: a CNT write with bit31=1 to a disabled channel copies shadows into the working registers. If timing=0, pending is set.
- Triggers: a vblank pulse sets pending on enabled channels with timing 1; an hblank pulse does the same for timing 2. Timing 3 never triggers. A trigger on an already-pending channel has no effect.
- Address control:
  - 0: increment.
  - 1: decrement.
  - 2: fixed.
  - 3: dest increment with DAD reload on repeat; src treated as fixed.
  - Step size is 4 (32-bit) or 2. Addresses are force-aligned: bit0 masked for halfword, [1:0] masked for word.
- Owner FSM has states CPU, DMA_RD, DMA_WR.
  - CPU: mem_* = cpu_* combinationally, cpu_ok = mem_ok.
  - CPU→DMA_RD happens when any channel is pending and (no cpu_read/write, or cpu_ok this cycle). The lowest channel number wins.
  - DMA_RD: assert mem_read at src with the channel width; latch mem_rdata on mem_ok → DMA_WR.
  - DMA_WR: assert mem_write at dst with the latched data; on mem_ok, step addresses and decrement count.
  - After a unit: if count reaches 0, the channel completes. Next state is DMA_RD for the highest-priority pending channel, else CPU.
- Preemption: a higher-priority channel going pending mid-transfer takes over at the next unit boundary. The lower channel keeps its working state and resumes afterwards.
- Completion: irq[ch] pulses if irq_en.
  - If repeat=1 and timing≠0: reload count (and DAD if dest ctl 3), clear pending, stay enabled.
  - Otherwise clear enable.
- CNT write with bit31=0 on an active channel aborts it at the next unit boundary, after the in-flight write completes. SAD/DAD writes only touch shadows.
- While owner≠CPU: cpu_ok=0 and CPU strobes are ignored.

## Timing
- Reset (rstn low at posedge):
  - Owner=CPU; all channels disabled, not pending; working registers 0.
  - DMA strobes 0 from the next cycle; irq=0, ch_en=0.
  - The CPU pass-through path remains combinational.
- With a zero-wait memory (mem_ok same cycle), one unit takes 2 cycles and the first DMA_RD starts 1 cycle after the grant decision.
- Return to CPU happens the cycle after the last mem_ok; the CPU request is forwarded that cycle.
- irq pulses in the cycle after the final write's mem_ok.
- cfg_we and a trigger in the same cycle on the same channel: the enable is processed; the trigger counts only if it matches timing on an already-enabled channel.

## Structure
- Package `dma_pkg`:
  - width codes, timing codes (IMM/VBL/HBL/SPC), address-control codes, cfg_reg selects;
  - CNT bit-field positions;
  - owner FSM state enum.
- Sub-module `dma_channel`, instantiated 4×: shadow/working registers, pending logic, address stepping, completion/reload. The top holds the priority encoder, the owner FSM and the bus mux.

## Test plan
- **Immediate word copy:** ch0 SAD=0x02000000, DAD=0x03000000, CNT count=4, 32-bit, enable, with zero-wait memory → 4 word copies in 8 cycles, irq[0] pulse, ch_en[0]=0.
- **CPU stall:** CPU read in flight while ch1 is enabled → grant only after that cpu_ok; a CPU request issued during DMA gets cpu_ok only after owner returns to CPU.
- **Preemption:** ch3 is copying 8 halfwords; ch0 is enabled after unit 2 → ch0 runs fully, then ch3 resumes at unit 3 with correct src/dst.
- **Repeat HBL:** ch2 with dest ctl 3, repeat, timing=2, count=2 → each trig_hblank copies 2 units; DAD restored each time; ch_en stays 1.
- **Address control:** decrement src, fixed dst, halfword, SAD=0x103 → reads at 0x102, 0x100, 0x0FE.
- **Abort and reset:** CNT write with enable=0 mid-transfer stops after the current unit with no irq; rstn low mid-DMA_RD drops mem_read the next cycle with all channels disabled.
